// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// redirect mode encodings and the instruction word width.
package fetch_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        FULL  = 2'b10,
        DRAIN = 2'b11
    } state_t;

    localparam logic [1:0] REDIR_NONE = 2'b00;
    localparam logic [1:0] REDIR_BR   = 2'b01;
    localparam logic [1:0] REDIR_J    = 2'b10;
    localparam logic [1:0] REDIR_JR   = 2'b11;

endpackage

// File: rtl/fetch_target.sv
// Redirect target calculation for branch, jump and jump-register, plus the
// misalignment flag for jump-register targets.
module fetch_target
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   base,
    input  logic [INSTR_W-1:0] imm,
    input  logic [WIDTH-1:0]   reg_val,
    output logic [WIDTH-1:0]   target,
    output logic               misalign
);

    logic [WIDTH-1:0] imm_ext;

    assign imm_ext = WIDTH'($signed(imm));

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        target   = base;
        misalign = 1'b0;
        case (mode)
            REDIR_BR: target = base + (imm_ext << 2);
            REDIR_J:  target = {base[WIDTH-1:28], imm[25:0], 2'b00};
            REDIR_JR: begin
                target   = {reg_val[WIDTH-1:2], 2'b00};
                misalign = (reg_val[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack handshake into a
// DEPTH-entry buffer, and flushes/redirects on branch, jump and jr.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [WIDTH-1:0]   imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [WIDTH-1:0]   instr_pc,
    output logic [WIDTH-1:0]   instr_pcplus4,
    input  logic [1:0]         redir_mode,
    input  logic [WIDTH-1:0]   redir_base,
    input  logic [INSTR_W-1:0] redir_imm,
    input  logic [WIDTH-1:0]   redir_reg,
    output logic               misalign
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    state_t state, state_next;

    logic [WIDTH-1:0]   fetch_pc;
    logic [WIDTH-1:0]   drain_addr;
    logic [CW-1:0]      count, count_next;
    logic [PW-1:0]      rd_ptr, wr_ptr;
    logic [INSTR_W-1:0] buf_instr [DEPTH];
    logic [WIDTH-1:0]   buf_pc    [DEPTH];

    logic               redirect, push, pop;
    logic [WIDTH-1:0]   target;
    logic               target_misalign;

    fetch_target #(.WIDTH(WIDTH)) u_target (
        .mode     (redir_mode),
        .base     (redir_base),
        .imm      (redir_imm),
        .reg_val  (redir_reg),
        .target   (target),
        .misalign (target_misalign)
    );

    // A redirect flushes the buffer, so it suppresses both push and pop.
    assign redirect    = (redir_mode != REDIR_NONE);
    assign instr_valid = (count != '0);
    assign push        = (state == FETCH) && imem_ack && !redirect;
    assign pop         = instr_valid && instr_ready && !redirect;
    assign count_next  = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  state_next = FETCH;
            FETCH: begin
                if (redirect)                                state_next = imem_ack ? FETCH : DRAIN;
                else if (imem_ack && count_next == CW'(DEPTH)) state_next = FULL;
                else                                         state_next = FETCH;
            end
            FULL:  if (redirect || pop) state_next = FETCH;
            DRAIN: if (imem_ack) state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    // While draining, the bus keeps the address of the abandoned request.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = fetch_pc;
        case (state)
            FETCH: imem_req = 1'b1;
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            drain_addr <= RESET_PC;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            misalign   <= 1'b0;
        end else begin
            misalign <= target_misalign;
            if (redirect) begin
                fetch_pc <= target;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                if (state == FETCH && !imem_ack) drain_addr <= fetch_pc;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + WIDTH'(4);
                    wr_ptr   <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count_next;
            end
        end
    end

    // NOTE: buffer storage has no reset; entries are only observed once count marks them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]    <= fetch_pc;
        end
    end

    assign instr         = buf_instr[rd_ptr];
    assign instr_pc      = buf_pc[rd_ptr];
    assign instr_pcplus4 = instr_pc + WIDTH'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus queues expected PCs, a monitor pops
// and compares them on every decode handshake.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcplus4;
    logic [1:0]  redir_mode;
    logic [31:0] redir_base;
    logic [31:0] redir_imm;
    logic [31:0] redir_reg;
    logic        misalign;
    logic        ack_en;

    int vectors     = 0;
    int miscompares = 0;
    int pops        = 0;
    logic [31:0] exp_q [$];

    fetch_unit #(.WIDTH(32), .DEPTH(2), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_pcplus4 (instr_pcplus4),
        .redir_mode    (redir_mode),
        .redir_base    (redir_base),
        .redir_imm     (redir_imm),
        .redir_reg     (redir_reg),
        .misalign      (misalign)
    );

    always #5 clk = ~clk;

    // Memory model: zero-wait when ack_en, word content derived from address.
    assign imem_ack   = ack_en & imem_req;
    assign imem_rdata = imem_addr ^ KEY;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic redirect(input logic [1:0] mode, input logic [31:0] base,
                            input logic [31:0] imm, input logic [31:0] rv);
        redir_mode = mode;
        redir_base = base;
        redir_imm  = imm;
        redir_reg  = rv;
    endtask

    // Ends in the IDLE cycle right after reset release.
    task automatic do_reset();
        reset      = 1'b1;
        redir_mode = 2'b00;
        exp_q.delete();
        pops = 0;
        tick();
        tick();
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_misalign", {31'b0, misalign}, 32'd0);
        reset = 1'b0;
        check("idle_req", {31'b0, imem_req}, 32'd0);
    endtask

    // Scoreboard monitor: every accepted instruction must match the queue head.
    always @(negedge clk) begin
        if (!reset && redir_mode == 2'b00 && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", instr_pc, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("pop_pc", instr_pc, e);
                check("pop_instr", instr, e ^ KEY);
                check("pop_pcplus4", instr_pcplus4, e + 32'd4);
            end
            pops++;
        end
    end

    initial begin
        reset       = 1'b1;
        instr_ready = 1'b1;
        ack_en      = 1'b1;
        redirect(2'b00, 32'h0, 32'h0, 32'h0);

        // Streaming with zero-wait memory: one new address per cycle.
        do_reset();
        expect_seq(32'h0, 16);
        tick();
        for (int i = 0; i < 6; i++) begin
            check("stream_req", {31'b0, imem_req}, 32'd1);
            check("stream_addr", imem_addr, 32'(4 * i));
            tick();
        end
        check("stream_pops", 32'(pops), 32'd5);

        // Back-pressure fills the two-entry buffer, then one pop restarts fetch.
        instr_ready = 1'b0;
        do_reset();
        expect_seq(32'h0, 16);
        tick();
        check("bp_addr0", imem_addr, 32'h0);
        tick();
        check("bp_addr4", imem_addr, 32'h4);
        check("bp_valid", {31'b0, instr_valid}, 32'd1);
        tick();
        check("full_req", {31'b0, imem_req}, 32'd0);
        tick();
        check("full_req_hold", {31'b0, imem_req}, 32'd0);
        check("full_no_pop", 32'(pops), 32'd0);
        instr_ready = 1'b1;
        tick();
        check("refetch_req", {31'b0, imem_req}, 32'd1);
        check("refetch_addr", imem_addr, 32'h8);
        check("refetch_pops", 32'(pops), 32'd1);

        // Branch: 0x100 + (-4 << 2) = 0xF0.
        tick();
        redirect(2'b01, 32'h0000_0100, 32'hFFFF_FFFC, 32'h0);
        expect_seq(32'h0000_00F0, 8);
        tick();
        redirect(2'b00, 32'h0, 32'h0, 32'h0);
        check("br_addr", imem_addr, 32'h0000_00F0);
        check("br_flush", {31'b0, instr_valid}, 32'd0);
        tick();
        check("br_valid", {31'b0, instr_valid}, 32'd1);
        tick();

        // Jump: {0x4, 0x40, 00} = 0x4000_0100.
        redirect(2'b10, 32'h4000_0010, 32'h0000_0040, 32'h0);
        expect_seq(32'h4000_0100, 8);
        tick();
        redirect(2'b00, 32'h0, 32'h0, 32'h0);
        check("j_addr", imem_addr, 32'h4000_0100);
        check("j_flush", {31'b0, instr_valid}, 32'd0);
        tick();
        check("j_next", imem_addr, 32'h4000_0104);
        tick();

        // Jump-register with misaligned value: target 0x200, one-cycle flag.
        check("jr_misalign_pre", {31'b0, misalign}, 32'd0);
        redirect(2'b11, 32'h0, 32'h0, 32'h0000_0203);
        expect_seq(32'h0000_0200, 8);
        tick();
        redirect(2'b00, 32'h0, 32'h0, 32'h0);
        check("jr_addr", imem_addr, 32'h0000_0200);
        check("jr_misalign", {31'b0, misalign}, 32'd1);
        tick();
        check("jr_misalign_clr", {31'b0, misalign}, 32'd0);
        tick();
        check("jr_stream", imem_addr, 32'h0000_0208);

        // Redirect while ack is withheld: stale address held until the late ack.
        ack_en = 1'b0;
        redirect(2'b01, 32'h0000_1000, 32'h0000_0010, 32'h0);
        exp_q.delete();
        tick();
        check("drain_req", {31'b0, imem_req}, 32'd1);
        check("drain_addr1", imem_addr, 32'h0000_0208);
        check("drain_valid", {31'b0, instr_valid}, 32'd0);
        redirect(2'b01, 32'h0000_2000, 32'h0000_0004, 32'h0);
        tick();
        redirect(2'b00, 32'h0, 32'h0, 32'h0);
        check("drain_addr2", imem_addr, 32'h0000_0208);
        tick();
        check("drain_addr3", imem_addr, 32'h0000_0208);
        ack_en = 1'b1;
        expect_seq(32'h0000_2010, 8);
        tick();
        check("drain_target", imem_addr, 32'h0000_2010);
        check("drain_discard", {31'b0, instr_valid}, 32'd0);
        tick();
        check("drain_valid_tgt", {31'b0, instr_valid}, 32'd1);
        tick();

        // Asynchronous reset in the middle of a fetch.
        reset = 1'b1;
        #1;
        check("async_req", {31'b0, imem_req}, 32'd0);
        check("async_valid", {31'b0, instr_valid}, 32'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        expect_seq(32'h0, 8);
        check("rerst_idle", {31'b0, imem_req}, 32'd0);
        tick();
        check("rerst_req", {31'b0, imem_req}, 32'd1);
        check("rerst_addr", imem_addr, 32'h0);
        tick();
        check("rerst_next", imem_addr, 32'h4);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
